// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one external memory bus port between fetch and data access
// Data wins ties; a starve counter forces a fetch grant after STARVE_LIMIT data grants.

module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [63:0] if_addr_i,
   input  logic        if_flush_i,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   output logic        if_stall_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [63:0] d_addr_i,
   input  logic [63:0] d_wdata_i,
   input  logic [7:0]  d_wstrb_i,
   output logic        d_rvalid_o,
   output logic [63:0] d_rdata_o,
   output logic        d_err_o,
   output logic        d_stall_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [63:0] bus_addr_o,
   output logic [63:0] bus_wdata_o,
   output logic [7:0]  bus_wstrb_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [63:0] bus_rdata_i,
   input  logic        bus_err_i
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   localparam logic [3:0] LIMIT  = STARVE_LIMIT[3:0];
   localparam logic       OWN_IF = 1'b0;
   localparam logic       OWN_D  = 1'b1;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        discard_q, discard_d;
   logic        addr2_q, addr2_d;
   logic [3:0]  starve_q, starve_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [63:0] bus_addr_q, bus_addr_d;
   logic [63:0] bus_wdata_q, bus_wdata_d;
   logic [7:0]  bus_wstrb_q, bus_wstrb_d;

   logic if_win, d_win, rsp_fire;
   logic unused_if_addr;

   assign unused_if_addr = ^if_addr_i[1:0];

   // A fetch being flushed this cycle never competes for the bus.
   assign if_win = if_req_i & ~if_flush_i & (~d_req_i | (starve_q == LIMIT));
   assign d_win  = d_req_i & ~if_win;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      discard_d   = discard_q;
      addr2_d     = addr2_q;
      starve_d    = starve_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      case (state_q)
         IDLE: begin
            discard_d = 1'b0;
            if (if_win) begin
               state_d     = REQ;
               owner_d     = OWN_IF;
               addr2_d     = if_addr_i[2];
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = {if_addr_i[63:3], 3'b000};
               bus_wdata_d = '0;
               bus_wstrb_d = '0;
            end else if (d_win) begin
               state_d     = REQ;
               owner_d     = OWN_D;
               bus_req_d   = 1'b1;
               bus_we_d    = d_we_i;
               bus_addr_d  = d_addr_i;
               bus_wdata_d = d_wdata_i;
               bus_wstrb_d = d_we_i ? d_wstrb_i : 8'h00;
            end
            if (d_win && if_req_i) begin
               if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
            end else if (if_win || !if_req_i) begin
               starve_d = '0;
            end
         end
         REQ: begin
            if (owner_q == OWN_IF && if_flush_i) discard_d = 1'b1;
            if (bus_gnt_i) begin
               state_d   = RSP;
               bus_req_d = 1'b0;
            end
         end
         RSP: begin
            if (owner_q == OWN_IF && if_flush_i) discard_d = 1'b1;
            if (bus_rvalid_i) begin
               state_d   = IDLE;
               discard_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         discard_q   <= 1'b0;
         addr2_q     <= 1'b0;
         starve_q    <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         discard_q   <= discard_d;
         addr2_q     <= addr2_d;
         starve_q    <= starve_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_wstrb_o = bus_wstrb_q;

   // Responses are routed combinationally in the bus_rvalid_i cycle.
   assign rsp_fire    = (state_q == RSP) & bus_rvalid_i;
   assign if_rvalid_o = rsp_fire & (owner_q == OWN_IF) & ~discard_q & ~if_flush_i;
   assign if_rdata_o  = if_rvalid_o ? (addr2_q ? bus_rdata_i[63:32] : bus_rdata_i[31:0]) : 32'h0;
   assign if_err_o    = if_rvalid_o & bus_err_i;
   assign d_rvalid_o  = rsp_fire & (owner_q == OWN_D);
   assign d_rdata_o   = d_rvalid_o ? bus_rdata_i : 64'h0;
   assign d_err_o     = d_rvalid_o & bus_err_i;

   assign if_stall_o  = reset & if_req_i & ~if_rvalid_o & ~if_flush_i;
   assign d_stall_o   = reset & d_req_i & ~d_rvalid_o;

endmodule
